// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 Hz timing constants and the coordinate type used by the
// sync counters and the pixel logic downstream.
package vga_timing_pkg;

  localparam int H_VIS  = 640;
  localparam int H_FP   = 16;
  localparam int H_SYNC = 96;
  localparam int H_BP   = 48;
  localparam int V_VIS  = 480;
  localparam int V_FP   = 10;
  localparam int V_SYNC = 2;
  localparam int V_BP   = 33;

  localparam int H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;

  localparam int H_SYNC_START = H_VIS + H_FP;
  localparam int H_SYNC_END   = H_SYNC_START + H_SYNC;
  localparam int V_SYNC_START = V_VIS + V_FP;
  localparam int V_SYNC_END   = V_SYNC_START + V_SYNC;

  localparam int BLINK_FRAMES = 15;

  typedef logic [9:0] coord_t;

endpackage

// File: rtl/sync_axis_cnt.sv
// One timing axis: wrapping position counter with registered sync and
// visible decodes that always describe the count being loaded.
module sync_axis_cnt
  import vga_timing_pkg::*;
#(
  parameter int VIS  = H_VIS,
  parameter int FP   = H_FP,
  parameter int SYNC = H_SYNC,
  parameter int BP   = H_BP
) (
  input  logic   CLK_NX,
  input  logic   reset,
  input  logic   en,
  output logic   wrap,
  output coord_t count,
  output logic   sync,
  output logic   visible
);

  localparam coord_t LAST       = coord_t'(VIS + FP + SYNC + BP - 1);
  localparam coord_t SYNC_START = coord_t'(VIS + FP);
  localparam coord_t SYNC_END   = coord_t'(VIS + FP + SYNC);
  localparam coord_t VIS_END    = coord_t'(VIS);

  coord_t count_reg;
  coord_t count_next;
  logic   sync_reg;
  logic   visible_reg;

  // wrap means "the next enabled step returns to zero"; the other axis and
  // the frame logic qualify it with their own enable.
  assign wrap       = (count_reg == LAST);
  assign count_next = wrap ? '0 : count_reg + coord_t'(1);

  always_ff @(posedge CLK_NX) begin
    if (reset) begin
      count_reg   <= '0;
      sync_reg    <= 1'b1;
      visible_reg <= 1'b1;
    end else if (en) begin
      count_reg   <= count_next;
      sync_reg    <= !((count_next >= SYNC_START) && (count_next < SYNC_END));
      visible_reg <= (count_next < VIS_END);
    end
  end

  assign count   = count_reg;
  assign sync    = sync_reg;
  assign visible = visible_reg;

endmodule

// File: rtl/vga_sync_ctrl.sv
// VGA raster sequencer: horizontal and vertical axis counters advanced by the
// pixel strobe, plus a frame counter that derives the alarm blink phase.
module vga_sync_ctrl
  import vga_timing_pkg::*;
#(
  parameter int H_VIS        = vga_timing_pkg::H_VIS,
  parameter int H_FP         = vga_timing_pkg::H_FP,
  parameter int H_SYNC       = vga_timing_pkg::H_SYNC,
  parameter int H_BP         = vga_timing_pkg::H_BP,
  parameter int V_VIS        = vga_timing_pkg::V_VIS,
  parameter int V_FP         = vga_timing_pkg::V_FP,
  parameter int V_SYNC       = vga_timing_pkg::V_SYNC,
  parameter int V_BP         = vga_timing_pkg::V_BP,
  parameter int BLINK_FRAMES = vga_timing_pkg::BLINK_FRAMES
) (
  input  logic   CLK_NX,
  input  logic   reset,
  input  logic   pix_en,
  input  logic   blink_en,
  output logic   hsync,
  output logic   vsync,
  output logic   video_on,
  output coord_t pixel_x,
  output coord_t pixel_y,
  output logic   frame_tick,
  output logic   blink
);

  localparam logic [3:0] BLINK_LAST = 4'(BLINK_FRAMES - 1);

  logic h_wrap, v_wrap, v_en, frame_wrap;
  logic h_vis, v_vis;

  logic [3:0] frame_cnt_reg;
  logic       phase_reg;
  logic       frame_tick_reg;

  sync_axis_cnt #(.VIS(H_VIS), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP)) u_h_axis (
    .CLK_NX  (CLK_NX),
    .reset   (reset),
    .en      (pix_en),
    .wrap    (h_wrap),
    .count   (pixel_x),
    .sync    (hsync),
    .visible (h_vis)
  );

  assign v_en = pix_en & h_wrap;

  sync_axis_cnt #(.VIS(V_VIS), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP)) u_v_axis (
    .CLK_NX  (CLK_NX),
    .reset   (reset),
    .en      (v_en),
    .wrap    (v_wrap),
    .count   (pixel_y),
    .sync    (vsync),
    .visible (v_vis)
  );

  assign frame_wrap = v_en & v_wrap;

  // frame_tick is registered from the same qualified wrap that zeroes both
  // counters, so it lands on the edge that shows (0,0).
  always_ff @(posedge CLK_NX) begin
    if (reset) begin
      frame_cnt_reg  <= '0;
      phase_reg      <= 1'b0;
      frame_tick_reg <= 1'b0;
    end else begin
      frame_tick_reg <= frame_wrap;
      if (frame_wrap) begin
        if (frame_cnt_reg == BLINK_LAST) begin
          frame_cnt_reg <= '0;
          phase_reg     <= ~phase_reg;
        end else begin
          frame_cnt_reg <= frame_cnt_reg + 4'd1;
        end
      end
    end
  end

  assign video_on   = h_vis & v_vis;
  assign frame_tick = frame_tick_reg;
  assign blink      = phase_reg | ~blink_en;

endmodule

// File: tb/tb_vga_sync_ctrl.sv
// Randomized-strobe bench for vga_sync_ctrl; a reduced raster keeps whole
// frames and blink periods short while exercising every boundary.
module tb_vga_sync_ctrl;

  localparam int HV = 16, HF = 4, HS = 6, HB = 6;
  localparam int VV = 12, VF = 2, VS = 2, VB = 3;
  localparam int BF = 15;
  localparam int HT = HV + HF + HS + HB;
  localparam int VT = VV + VF + VS + VB;
  localparam int FRAME = HT * VT;

  logic       CLK_NX = 1'b0;
  logic       reset = 1'b1;
  logic       pix_en = 1'b0;
  logic       blink_en = 1'b1;
  logic       hsync, vsync, video_on, frame_tick, blink;
  logic [9:0] pixel_x, pixel_y;

  int     compares = 0;
  int     fails = 0;
  longint n = 0;          // strobes accepted since the last reset
  logic   tick_exp = 1'b0;

  always #5 CLK_NX = ~CLK_NX;

  vga_sync_ctrl #(
    .H_VIS(HV), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_VIS(VV), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .BLINK_FRAMES(BF)
  ) dut (
    .CLK_NX     (CLK_NX),
    .reset      (reset),
    .pix_en     (pix_en),
    .blink_en   (blink_en),
    .hsync      (hsync),
    .vsync      (vsync),
    .video_on   (video_on),
    .pixel_x    (pixel_x),
    .pixel_y    (pixel_y),
    .frame_tick (frame_tick),
    .blink      (blink)
  );

  // Reference model: everything follows from the strobe count alone.
  function automatic int ex();
    return int'(n % HT);
  endfunction

  function automatic int ey();
    return int'((n / HT) % VT);
  endfunction

  function automatic logic exp_blink();
    return (((n / FRAME) / BF) % 2 == 1) || !blink_en;
  endfunction

  function automatic logic [24:0] exp_vec();
    int x, y;
    x = ex();
    y = ey();
    return {10'(x), 10'(y),
            !(x >= HV + HF && x < HV + HF + HS),
            !(y >= VV + VF && y < VV + VF + VS),
            (x < HV) && (y < VV),
            tick_exp,
            exp_blink()};
  endfunction

  function automatic logic [24:0] act_vec();
    return {pixel_x, pixel_y, hsync, vsync, video_on, frame_tick, blink};
  endfunction

  task automatic step(input logic en);
    pix_en = en;
    @(posedge CLK_NX);
    #1;
    if (reset) begin
      n = 0;
      tick_exp = 1'b0;
    end else if (en) begin
      n++;
      tick_exp = (n % FRAME == 0);
    end else begin
      tick_exp = 1'b0;
    end
    pix_en = 1'b0;
  endtask

  task automatic run_to(input longint target, input int pct);
    while (n < target) step(($urandom_range(99) < pct) ? 1'b1 : 1'b0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step(1'b0);
    step(1'b0);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step(1'b1);
    step(1'b1);
    compares++;
    if (act_vec() !== exp_vec()) begin
      fails++;
      $display("FAIL reset_state: got %h expected %h", act_vec(), exp_vec());
    end
    compares++;
    if ({pixel_x, pixel_y, hsync, vsync, video_on, frame_tick, blink} !== {20'd0, 5'b11100}) begin
      fails++;
      $display("FAIL reset_values: got x=%0d y=%0d hs=%b vs=%b vo=%b ft=%b bl=%b required 0 0 1 1 1 0 0",
               pixel_x, pixel_y, hsync, vsync, video_on, frame_tick, blink);
    end
    reset = 1'b0;
    $display("test_reset done: x=%0d y=%0d", pixel_x, pixel_y);
  endtask

  task automatic test_first_pixels();
    do_reset();
    step(1'b1);
    compares++;
    if ({pixel_x, pixel_y, video_on, hsync} !== {10'd1, 10'd0, 2'b11}) begin
      fails++;
      $display("FAIL first_strobe: got x=%0d y=%0d vo=%b hs=%b required 1 0 1 1",
               pixel_x, pixel_y, video_on, hsync);
    end
    run_to(HV - 1, 70);
    compares++;
    if (video_on !== 1'b1) begin
      fails++;
      $display("FAIL last_visible_x: got video_on=%b required 1 at x=%0d", video_on, pixel_x);
    end
    run_to(HV, 70);
    compares++;
    if (pixel_x !== 10'(HV) || video_on !== 1'b0) begin
      fails++;
      $display("FAIL first_blank_x: got x=%0d vo=%b required x=%0d vo=0", pixel_x, video_on, HV);
    end
    $display("test_first_pixels done: x=%0d video_on=%b", pixel_x, video_on);
  endtask

  task automatic test_hsync();
    run_to(HV + HF - 1, 60);
    compares++;
    if (hsync !== 1'b1) begin
      fails++;
      $display("FAIL hsync_before: got %b required 1 at x=%0d", hsync, pixel_x);
    end
    run_to(HV + HF, 60);
    compares++;
    if (hsync !== 1'b0) begin
      fails++;
      $display("FAIL hsync_start: got %b required 0 at x=%0d", hsync, pixel_x);
    end
    run_to(HV + HF + HS - 1, 60);
    compares++;
    if (hsync !== 1'b0) begin
      fails++;
      $display("FAIL hsync_last: got %b required 0 at x=%0d", hsync, pixel_x);
    end
    run_to(HV + HF + HS, 60);
    compares++;
    if (hsync !== 1'b1) begin
      fails++;
      $display("FAIL hsync_end: got %b required 1 at x=%0d", hsync, pixel_x);
    end
    run_to(HT, 60);
    compares++;
    if (pixel_x !== 10'd0 || pixel_y !== 10'd1) begin
      fails++;
      $display("FAIL line_wrap: got x=%0d y=%0d required 0 1", pixel_x, pixel_y);
    end
    $display("test_hsync done: x=%0d y=%0d", pixel_x, pixel_y);
  endtask

  task automatic test_full_frame();
    int ticks = 0;
    int vs_low = 0;
    do_reset();
    while (n < FRAME) begin
      step(($urandom_range(99) < 75) ? 1'b1 : 1'b0);
      if (frame_tick === 1'b1) ticks++;
      if (vsync === 1'b0) vs_low++;
      compares++;
      if (act_vec() !== exp_vec()) begin
        fails++;
        $display("FAIL frame_walk n=%0d: got %h expected %h", n, act_vec(), exp_vec());
      end
    end
    compares++;
    if (ticks !== 1 || frame_tick !== 1'b1 || pixel_x !== 10'd0 || pixel_y !== 10'd0) begin
      fails++;
      $display("FAIL frame_tick_once: got ticks=%0d ft=%b x=%0d y=%0d required 1 1 0 0",
               ticks, frame_tick, pixel_x, pixel_y);
    end
    step(1'b0);
    compares++;
    if (frame_tick !== 1'b0) begin
      fails++;
      $display("FAIL frame_tick_width: got %b required 0", frame_tick);
    end
    $display("test_full_frame done: ticks=%0d vsync_low_cycles=%0d", ticks, vs_low);
  endtask

  task automatic test_hold();
    run_to(FRAME + 3 * HT + HV / 2, 80);
    repeat (1000) begin
      step(1'b0);
      compares++;
      if (act_vec() !== exp_vec() || frame_tick !== 1'b0) begin
        fails++;
        $display("FAIL hold: got %h expected %h", act_vec(), exp_vec());
      end
    end
    $display("test_hold done: x=%0d y=%0d", pixel_x, pixel_y);
  endtask

  task automatic test_blink();
    do_reset();
    run_to(longint'(BF) * FRAME - 1, 100);
    compares++;
    if (blink !== 1'b0) begin
      fails++;
      $display("FAIL blink_before: got %b required 0", blink);
    end
    step(1'b1);
    compares++;
    if (frame_tick !== 1'b1 || blink !== 1'b1) begin
      fails++;
      $display("FAIL blink_toggle: got ft=%b blink=%b required 1 1", frame_tick, blink);
    end
    blink_en = 1'b0;
    #1;
    compares++;
    if (blink !== 1'b1) begin
      fails++;
      $display("FAIL blink_forced: got %b required 1", blink);
    end
    run_to(longint'(2 * BF) * FRAME, 100);
    compares++;
    if (blink !== 1'b1) begin
      fails++;
      $display("FAIL blink_forced_hold: got %b required 1", blink);
    end
    blink_en = 1'b1;
    #1;
    compares++;
    if (blink !== 1'b0 || blink !== exp_blink()) begin
      fails++;
      $display("FAIL blink_restore: got %b required 0", blink);
    end
    $display("test_blink done: blink=%b n=%0d", blink, n);
  endtask

  task automatic test_reset_mid();
    do_reset();
    run_to(longint'(BF) * FRAME + (VV / 2) * HT + HV + HF + 2, 100);
    compares++;
    if (blink !== 1'b1) begin
      fails++;
      $display("FAIL mid_phase: got blink=%b required 1", blink);
    end
    reset = 1'b1;
    step(1'b1);
    reset = 1'b0;
    compares++;
    if ({pixel_x, pixel_y, hsync, vsync, video_on, frame_tick, blink} !== {20'd0, 5'b11100}) begin
      fails++;
      $display("FAIL reset_mid: got x=%0d y=%0d hs=%b vs=%b vo=%b ft=%b bl=%b required 0 0 1 1 1 0 0",
               pixel_x, pixel_y, hsync, vsync, video_on, frame_tick, blink);
    end
    $display("test_reset_mid done: x=%0d y=%0d", pixel_x, pixel_y);
  endtask

  task automatic test_back_to_back();
    int ticks = 0;
    do_reset();
    repeat (4000) begin
      if ($urandom_range(99) < 2) blink_en = ~blink_en;
      step(($urandom_range(99) < 90) ? 1'b1 : 1'b0);
      if (frame_tick === 1'b1) ticks++;
      compares++;
      if (act_vec() !== exp_vec()) begin
        fails++;
        $display("FAIL random_walk n=%0d: got %h expected %h", n, act_vec(), exp_vec());
      end
    end
    blink_en = 1'b1;
    $display("test_back_to_back done: strobes=%0d ticks=%0d", n, ticks);
  endtask

  initial begin
    test_reset();
    test_first_pixels();
    test_hsync();
    test_full_frame();
    test_hold();
    test_blink();
    test_reset_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compares, fails);
    $finish;
  end

endmodule
